benes_pass_scheduler: RTL and testbench

- Sequences one permutation pass of the 512-bit Benes interconnect: reads beats from the local coefficient buffer, routes them through the network, and writes the permuted beats back.
- Accepts one command per pass from the AXI4 slave register front end.
- Loads the network switch configuration only when it changes.
- Control only: data flows directly buffer -> network -> buffer; this block drives enables, addresses and config selects with fixed-latency alignment.

---
 rtl/benes_pass_scheduler_pkg.sv | 25 ++
 rtl/benes_pass_scheduler_valid_delay.sv | 41 ++++
 rtl/benes_pass_scheduler.sv | 141 ++++++++++++++
 tb/tb_benes_pass_scheduler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/benes_pass_scheduler_pkg.sv
// Shared types and defaults for the Benes permutation pass scheduler.
package benes_pass_scheduler_pkg;

  localparam int unsigned BENES_ADDR_W   = 10;
  localparam int unsigned BENES_LEN_W    = 8;
  localparam int unsigned BENES_CFG_ID_W = 4;
  localparam int unsigned BENES_NET_LAT  = 11;
  localparam int unsigned BENES_CFG_LAT  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } benes_sched_state_e;

  typedef struct packed {
    logic [BENES_ADDR_W-1:0]   src;
    logic [BENES_ADDR_W-1:0]   dst;
    logic [BENES_LEN_W-1:0]    len;
    logic [BENES_CFG_ID_W-1:0] cfg_id;
  } benes_cmd_t;

endpackage

// File: rtl/benes_pass_scheduler_valid_delay.sv
// Fixed-depth shift register of {valid, addr} with synchronous clear.
module benes_valid_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         in_valid,
  input  logic [W-1:0] in_addr,
  output logic         out_valid,
  output logic [W-1:0] out_addr,
  output logic         pending
);

  logic [DEPTH-1:0] v;
  logic [W-1:0]     a [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      v <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) a[i] <= '0;
    end else begin
      v[0] <= in_valid;
      a[0] <= in_addr;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        v[i] <= v[i-1];
        a[i] <= a[i-1];
      end
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_addr  = a[DEPTH-1];

  // Entries still to emerge after the current output cycle.
  always_comb begin
    pending = 1'b0;
    for (int unsigned i = 0; i + 1 < DEPTH; i++) pending = pending | v[i];
  end

endmodule

// File: rtl/benes_pass_scheduler.sv
// Sequences one Benes permutation pass: config load, beat reads, aligned write-back.
module benes_pass_scheduler
  import benes_pass_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_W   = BENES_ADDR_W,
  parameter int unsigned LEN_W    = BENES_LEN_W,
  parameter int unsigned CFG_ID_W = BENES_CFG_ID_W,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned NET_LAT  = BENES_NET_LAT,
  parameter int unsigned CFG_LAT  = BENES_CFG_LAT
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_areset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_src,
  input  logic [ADDR_W-1:0]   cmd_dst,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [CFG_ID_W-1:0] cmd_cfg_id,
  output logic                buf_rd_en,
  output logic [ADDR_W-1:0]   buf_rd_addr,
  output logic                net_cfg_load,
  output logic [CFG_ID_W-1:0] net_cfg_id,
  output logic                net_in_valid,
  output logic                buf_wr_en,
  output logic [ADDR_W-1:0]   buf_wr_addr,
  output logic                busy,
  output logic                done
);

  localparam int unsigned CNT_W = (CFG_LAT > 1) ? $clog2(CFG_LAT) : 1;

  benes_sched_state_e  state, state_d;
  benes_cmd_t          cmd_q;
  logic [LEN_W:0]      k;
  logic [CNT_W-1:0]    cfg_cnt;
  logic [CFG_ID_W-1:0] last_cfg_id;
  logic                cfg_loaded_valid;
  logic                cfg_hit;
  logic [ADDR_W-1:0]   wr_addr_in;
  logic                rd_pending, wr_pending;
  logic                unused_rd_tap;

  assign cfg_hit    = cfg_loaded_valid && (cmd_cfg_id == last_cfg_id);
  assign wr_addr_in = cmd_q.dst + ADDR_W'(k);
  assign busy       = (state != S_IDLE);
  assign net_cfg_id = cmd_q.cfg_id;

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state            <= S_IDLE;
      cmd_q            <= '0;
      k                <= '0;
      cfg_cnt          <= '0;
      last_cfg_id      <= '0;
      cfg_loaded_valid <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_q.src    <= cmd_src;
            cmd_q.dst    <= cmd_dst;
            cmd_q.len    <= cmd_len;
            cmd_q.cfg_id <= cmd_cfg_id;
            k            <= '0;
            cfg_cnt      <= '0;
          end
        end
        S_CFG: begin
          cfg_cnt <= cfg_cnt + 1'b1;
          if (cfg_cnt == '0) begin
            last_cfg_id      <= cmd_q.cfg_id;
            cfg_loaded_valid <= 1'b1;
          end
        end
        S_ISSUE: k <= k + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state;
    cmd_ready    = 1'b0;
    buf_rd_en    = 1'b0;
    buf_rd_addr  = '0;
    net_cfg_load = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = cfg_hit ? S_ISSUE : S_CFG;
      end
      S_CFG: begin
        net_cfg_load = (cfg_cnt == '0);
        if (cfg_cnt == CNT_W'(CFG_LAT - 1)) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        buf_rd_en   = 1'b1;
        buf_rd_addr = cmd_q.src + ADDR_W'(k);
        if (k == {1'b0, cmd_q.len}) state_d = S_DRAIN;
      end
      // The output stage of the write pipe fires in the same cycle we leave,
      // so done lands exactly one cycle after the last write.
      S_DRAIN: if (!(rd_pending || wr_pending)) state_d = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  benes_valid_delay #(
    .DEPTH (RD_LAT),
    .W     (1)
  ) u_rd_delay (
    .clk       (s_axi_aclk),
    .clear     (s_axi_areset),
    .in_valid  (buf_rd_en),
    .in_addr   (1'b0),
    .out_valid (net_in_valid),
    .out_addr  (unused_rd_tap),
    .pending   (rd_pending)
  );

  benes_valid_delay #(
    .DEPTH (RD_LAT + NET_LAT),
    .W     (ADDR_W)
  ) u_wr_delay (
    .clk       (s_axi_aclk),
    .clear     (s_axi_areset),
    .in_valid  (buf_rd_en),
    .in_addr   (wr_addr_in),
    .out_valid (buf_wr_en),
    .out_addr  (buf_wr_addr),
    .pending   (wr_pending)
  );

endmodule

// File: tb/tb_benes_pass_scheduler.sv
// Scoreboard bench: expected pulses queued at command acceptance, popped as the DUT emits them.
module tb_benes_pass_scheduler;

  localparam int CFG_LAT = 4;
  localparam int PIPE    = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [9:0] cmd_src = '0, cmd_dst = '0;
  logic [7:0] cmd_len = '0;
  logic [3:0] cmd_cfg_id = '0;
  logic       buf_rd_en, net_cfg_load, net_in_valid, buf_wr_en, busy, done;
  logic [9:0] buf_rd_addr, buf_wr_addr;
  logic [3:0] net_cfg_id;

  benes_pass_scheduler dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_src      (cmd_src),
    .cmd_dst      (cmd_dst),
    .cmd_len      (cmd_len),
    .cmd_cfg_id   (cmd_cfg_id),
    .buf_rd_en    (buf_rd_en),
    .buf_rd_addr  (buf_rd_addr),
    .net_cfg_load (net_cfg_load),
    .net_cfg_id   (net_cfg_id),
    .net_in_valid (net_in_valid),
    .buf_wr_en    (buf_wr_en),
    .buf_wr_addr  (buf_wr_addr),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t rd_q[$], wr_q[$], cfg_q[$], nv_q[$], done_q[$];
  int  cyc = 0;
  int  checks = 0, errors = 0;
  int  busy_until = 0;
  bit  mvalid = 1'b0;
  int  mlast = 0;
  bit  last_acc = 1'b0;
  int  wr_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic pop_ev(input string tag, inout ev_t q[$], input int val, input bit use_val);
    ev_t e;
    if (q.size() == 0) begin
      chk({tag, "_unexpected"}, 1, 0);
    end else begin
      e = q.pop_front();
      chk({tag, "_cycle"}, cyc, e.cyc);
      if (use_val) chk({tag, "_val"}, val, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmd_ready", int'(cmd_ready), int'(cyc > busy_until));
      chk("busy", int'(busy), int'(cyc <= busy_until));
      last_acc = cmd_valid && (cyc > busy_until);
      if (last_acc) begin
        int first, id, len;
        bit chg;
        id  = int'(cmd_cfg_id);
        len = int'(cmd_len);
        chg = !(mvalid && id == mlast);
        first = cyc + 1 + (chg ? CFG_LAT : 0);
        if (chg) cfg_q.push_back('{cyc + 1, id});
        mvalid = 1'b1;
        mlast  = id;
        for (int i = 0; i <= len; i++) begin
          rd_q.push_back('{first + i, (int'(cmd_src) + i) % 1024});
          nv_q.push_back('{first + i + 1, 0});
          wr_q.push_back('{first + i + PIPE, (int'(cmd_dst) + i) % 1024});
        end
        busy_until = first + len + PIPE + 1;
        done_q.push_back('{busy_until, 0});
      end
      if (buf_rd_en)    pop_ev("rd", rd_q, int'(buf_rd_addr), 1'b1);
      if (net_in_valid) pop_ev("net_in", nv_q, 0, 1'b0);
      if (buf_wr_en) begin
        wr_cnt++;
        pop_ev("wr", wr_q, int'(buf_wr_addr), 1'b1);
      end
      if (net_cfg_load) pop_ev("cfg_load", cfg_q, int'(net_cfg_id), 1'b1);
      if (done)         pop_ev("done", done_q, 0, 1'b0);
    end else begin
      last_acc = 1'b0;
    end
  end

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic send(input int src, input int dst, input int len, input int id);
    int n;
    @(posedge clk); #1;
    cmd_valid  = 1'b1;
    cmd_src    = 10'(src);
    cmd_dst    = 10'(dst);
    cmd_len    = 8'(len);
    cmd_cfg_id = 4'(id);
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!last_acc && n < 2000);
    if (!last_acc) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    rd_q.delete(); wr_q.delete(); cfg_q.delete(); nv_q.delete(); done_q.delete();
    mvalid     = 1'b0;
    busy_until = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int w0, n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("reset_rd_en", int'(buf_rd_en), 0);
    chk("reset_wr_en", int'(buf_wr_en), 0);
    chk("reset_done", int'(done), 0);

    send(12'h010, 12'h200, 3, 5);
    send(12'h3FF, 12'h3FF, 0, 5);
    send(12'h3FE, 12'h3FE, 3, 7);
    // Long pass; the follow-up command is presented while it runs.
    send(12'h020, 12'h100, 255, 7);
    send(12'h005, 12'h006, 1, 7);

    send(12'h040, 12'h050, 7, 7);
    w0 = wr_cnt;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (wr_cnt < w0 + 2 && n < 200);
    chk("reset_mid_writes_seen", int'(wr_cnt >= w0 + 2), 1);
    pulse_reset();
    send(12'h000, 12'h300, 2, 7);

    send(12'h001, 12'h002, 1, 2);
    send(12'h003, 12'h004, 2, 3);

    n = 0;
    while (cyc <= busy_until + 20 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("rd_left", rd_q.size(), 0);
    chk("wr_left", wr_q.size(), 0);
    chk("nv_left", nv_q.size(), 0);
    chk("cfg_left", cfg_q.size(), 0);
    chk("done_left", done_q.size(), 0);
    finish_run();
  end

  initial begin
    #500000;
    chk("global_timeout", 0, 1);
    finish_run();
  end

endmodule
